// File: rtl/mc_cu_pkg.sv
// Shared definitions for the multi-cycle control unit: FSM states, ALU codes,
// opcode/func constants and the decoded-instruction one-hot record.
package mc_cu_pkg;

  typedef enum logic [2:0] {
    S_IF  = 3'd0,
    S_ID  = 3'd1,
    S_EXE = 3'd2,
    S_MEM = 3'd3,
    S_WB  = 3'd4
  } state_t;

  localparam logic [3:0] ALUC_ADD = 4'b0000;
  localparam logic [3:0] ALUC_SUB = 4'b0100;
  localparam logic [3:0] ALUC_AND = 4'b0001;
  localparam logic [3:0] ALUC_OR  = 4'b0101;
  localparam logic [3:0] ALUC_XOR = 4'b0010;
  localparam logic [3:0] ALUC_LUI = 4'b0110;
  localparam logic [3:0] ALUC_SLL = 4'b0011;
  localparam logic [3:0] ALUC_SRL = 4'b0111;
  localparam logic [3:0] ALUC_SRA = 4'b1111;
  localparam logic [3:0] ALUC_HAM = 4'b1001;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;
  localparam logic [5:0] F_HAM = 6'b110001;

  typedef struct packed {
    logic i_add, i_sub, i_and, i_or, i_xor, i_sll, i_srl, i_sra, i_jr, i_ham;
    logic i_addi, i_andi, i_ori, i_xori, i_lui;
    logic i_lw, i_sw, i_beq, i_bne, i_j, i_jal;
  } instr_t;

endpackage

// File: rtl/mc_cu_if.sv
// Control-unit <-> datapath bundle: IR fields, flags and memory handshake in,
// control strobes and debug state out.
interface mc_cu_if;
  // Memory handshake: mem_req is the request; an access completes in any cycle
  // where mem_req && mem_ready. mem_ready is ignored while mem_req is low.
  logic [5:0] op;
  logic [5:0] func;
  logic       z;
  logic       mem_ready;
  logic       mem_req, iord, wpc, wir, wmem, wreg;
  logic       regrt, m2reg, shift, sext, jal, alusrca;
  logic [1:0] alusrcb;
  logic [3:0] aluc;
  logic [1:0] pcsource;
  logic [2:0] state;
  logic       ill_instr, mem_err;

  modport master (
    output op, func, z, mem_ready,
    input  mem_req, iord, wpc, wir, wmem, wreg, regrt, m2reg, shift, sext, jal,
           alusrca, alusrcb, aluc, pcsource, state, ill_instr, mem_err
  );

  modport slave (
    input  op, func, z, mem_ready,
    output mem_req, iord, wpc, wir, wmem, wreg, regrt, m2reg, shift, sext, jal,
           alusrca, alusrcb, aluc, pcsource, state, ill_instr, mem_err
  );
endinterface

// File: rtl/mc_cu_decode.sv
// Combinational op/func decode into instruction one-hots plus a legal flag.
// Optional Hamming R-type op enabled by defining HAMMING_EN.
module mc_decode
  import mc_cu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [5:0] func,
  output instr_t     instr,
  output logic       legal
);
  logic rtype;

  assign rtype = (op == OP_RTYPE);

  always_comb begin
    instr        = '0;
    instr.i_add  = rtype && (func == F_ADD);
    instr.i_sub  = rtype && (func == F_SUB);
    instr.i_and  = rtype && (func == F_AND);
    instr.i_or   = rtype && (func == F_OR);
    instr.i_xor  = rtype && (func == F_XOR);
    instr.i_sll  = rtype && (func == F_SLL);
    instr.i_srl  = rtype && (func == F_SRL);
    instr.i_sra  = rtype && (func == F_SRA);
    instr.i_jr   = rtype && (func == F_JR);
`ifdef HAMMING_EN
    instr.i_ham  = rtype && (func == F_HAM);
`else
    instr.i_ham  = 1'b0;
`endif
    instr.i_addi = (op == OP_ADDI);
    instr.i_andi = (op == OP_ANDI);
    instr.i_ori  = (op == OP_ORI);
    instr.i_xori = (op == OP_XORI);
    instr.i_lui  = (op == OP_LUI);
    instr.i_lw   = (op == OP_LW);
    instr.i_sw   = (op == OP_SW);
    instr.i_beq  = (op == OP_BEQ);
    instr.i_bne  = (op == OP_BNE);
    instr.i_j    = (op == OP_J);
    instr.i_jal  = (op == OP_JAL);
  end

  assign legal = |instr;
endmodule

// File: rtl/mc_cu.sv
// Multi-cycle MIPS-style control unit (IF/ID/EXE/MEM/WB) with bounded memory
// wait and timeout. Build option HAMMING_EN adds the Hamming R-type op.
module mc_cu
  import mc_cu_pkg::*;
#(
  parameter int WAIT_MAX = 15
) (
  input  logic    clock,
  input  logic    resetn,
  mc_cu_if.slave  cu
);
  localparam int CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            run_q, run_d;
  instr_t          ins;
  logic            legal;
  logic            r_alu, i_alu, taken, timeout;
  logic [3:0]      exe_aluc;

  mc_decode u_decode (
    .op    (cu.op),
    .func  (cu.func),
    .instr (ins),
    .legal (legal)
  );

  assign r_alu   = ins.i_add | ins.i_sub | ins.i_and | ins.i_or | ins.i_xor |
                   ins.i_sll | ins.i_srl | ins.i_sra | ins.i_ham;
  assign i_alu   = ins.i_addi | ins.i_andi | ins.i_ori | ins.i_xori | ins.i_lui;
  assign taken   = (ins.i_beq & cu.z) | (ins.i_bne & ~cu.z);
  assign timeout = !cu.mem_ready && (cnt_q == CNT_MAX);
  // run_q holds outputs off until the first edge after reset release.
  assign run_d   = 1'b1;
  assign cu.state = state_q;

  always_comb begin
    exe_aluc = ALUC_ADD;
    if (ins.i_sub | ins.i_beq | ins.i_bne)  exe_aluc = ALUC_SUB;
    else if (ins.i_and | ins.i_andi)        exe_aluc = ALUC_AND;
    else if (ins.i_or | ins.i_ori)          exe_aluc = ALUC_OR;
    else if (ins.i_xor | ins.i_xori)        exe_aluc = ALUC_XOR;
    else if (ins.i_lui)                     exe_aluc = ALUC_LUI;
    else if (ins.i_sll)                     exe_aluc = ALUC_SLL;
    else if (ins.i_srl)                     exe_aluc = ALUC_SRL;
    else if (ins.i_sra)                     exe_aluc = ALUC_SRA;
    else if (ins.i_ham)                     exe_aluc = ALUC_HAM;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = '0;
    cu.mem_req   = 1'b0;
    cu.iord      = 1'b0;
    cu.wpc       = 1'b0;
    cu.wir       = 1'b0;
    cu.wmem      = 1'b0;
    cu.wreg      = 1'b0;
    cu.regrt     = 1'b0;
    cu.m2reg     = 1'b0;
    cu.shift     = 1'b0;
    cu.sext      = 1'b0;
    cu.jal       = 1'b0;
    cu.alusrca   = 1'b0;
    cu.alusrcb   = 2'b00;
    cu.aluc      = ALUC_ADD;
    cu.pcsource  = 2'b00;
    cu.ill_instr = 1'b0;
    cu.mem_err   = 1'b0;
    if (run_q) begin
      unique case (state_q)
        S_IF: begin
          cu.mem_req = 1'b1;
          if (cu.mem_ready) begin
            cu.wir     = 1'b1;
            cu.wpc     = 1'b1;
            cu.alusrcb = 2'b01;
            state_d    = S_ID;
          end else if (timeout) begin
            cu.mem_err = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ID: begin
          // ALU computes the branch target here; the datapath latches it.
          cu.alusrcb = 2'b11;
          state_d    = S_IF;
          if (!legal) begin
            cu.ill_instr = 1'b1;
          end else if (ins.i_j) begin
            cu.wpc      = 1'b1;
            cu.pcsource = 2'b11;
          end else if (ins.i_jal) begin
            cu.wpc      = 1'b1;
            cu.pcsource = 2'b11;
            cu.wreg     = 1'b1;
            cu.jal      = 1'b1;
          end else if (ins.i_jr) begin
            cu.wpc      = 1'b1;
            cu.pcsource = 2'b10;
          end else begin
            state_d = S_EXE;
          end
        end
        S_EXE: begin
          cu.alusrca = 1'b1;
          cu.aluc    = exe_aluc;
          cu.shift   = ins.i_sll | ins.i_srl | ins.i_sra;
          if (ins.i_beq | ins.i_bne) begin
            if (taken) begin
              cu.wpc      = 1'b1;
              cu.pcsource = 2'b01;
            end
            state_d = S_IF;
          end else if (ins.i_lw | ins.i_sw) begin
            cu.alusrcb = 2'b10;
            cu.sext    = 1'b1;
            state_d    = S_MEM;
          end else begin
            cu.alusrcb = i_alu ? 2'b10 : 2'b00;
            cu.sext    = ins.i_addi;
            state_d    = S_WB;
          end
        end
        S_MEM: begin
          cu.mem_req = 1'b1;
          cu.iord    = 1'b1;
          if (cu.mem_ready) begin
            cu.wmem = ins.i_sw;
            state_d = ins.i_sw ? S_IF : S_WB;
          end else if (timeout) begin
            cu.mem_err = 1'b1;
            state_d    = S_IF;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WB: begin
          cu.wreg  = 1'b1;
          cu.regrt = i_alu | ins.i_lw;
          cu.m2reg = ins.i_lw;
          state_d  = S_IF;
        end
        default: state_d = S_IF;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IF;
      cnt_q   <= '0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      run_q   <= run_d;
    end
  end

  logic unused_r_alu;
  assign unused_r_alu = r_alu;
endmodule

// File: doc/mc_cu.md
MC_CU -- requirements
Module: mc_cu

Interface
REQ-001 Parameter WAIT_MAX, default 15: maximum mem_ready wait cycles per memory access before timeout.
REQ-002 clock  in  1  single clock; all state updates on rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 op, func  in  6 each  instruction fields from the IR.
REQ-005 z  in  1  ALU zero flag, valid in EXE.
REQ-006 mem_ready  in  1  memory handshake; access completes in any cycle where mem_req=1 and mem_ready=1.
REQ-007 mem_req  out  1  memory access request.
REQ-008 iord  out  1  address select: 0=PC, 1=ALU result register.
REQ-009 wpc, wir, wmem, wreg  out  1 each  write enables: PC, IR, memory, register file.
REQ-010 regrt, m2reg, shift, sext, jal  out  1 each  same meaning as the single-cycle control signals.
REQ-011 alusrca  out  1  ALU A select: 0=PC, 1=rs/shamt.
REQ-012 alusrcb  out  2  ALU B select: 00=rt, 01=constant 4, 10=extended imm, 11=sext imm<<2.
REQ-013 aluc  out  4  ALU operation, existing team encoding.
REQ-014 pcsource  out  2  00=ALU, 01=latched branch target, 10=rs, 11=jump address.
REQ-015 state  out  3  current FSM state, for debug.
REQ-016 ill_instr, mem_err  out  1 each  single-cycle error pulses.

Function
REQ-017 FSM states: IF, ID, EXE, MEM, WB; outputs are combinational from state, op, func, z, mem_ready.
REQ-018 IF: mem_req=1, iord=0; on mem_ready: wir=1, wpc=1, alusrca=0, alusrcb=01, aluc=add, pcsource=00, next=ID; otherwise remain in IF.
REQ-019 ID: alusrca=0, alusrcb=11, aluc=add, latching the branch target; j: wpc=1, pcsource=11, next=IF.
REQ-020 ID jal: wpc=1, pcsource=11, wreg=1, jal=1, next=IF; jr: wpc=1, pcsource=10, next=IF.
REQ-021 ID with an undecoded op/func: ill_instr=1 for one cycle, no write enables, next=IF.
REQ-022 ID for all other decoded instructions: next=EXE.
REQ-023 EXE beq/bne: aluc=sub, alusrca=1, alusrcb=00; wpc=1 with pcsource=01 only if (beq&z)|(bne&~z); next=IF.
REQ-024 EXE R-type/imm ALU ops: aluc/shift/sext/alusrcb per single-cycle decode, next=WB; lw/sw: aluc=add, alusrcb=10, sext=1, next=MEM.
REQ-025 MEM: mem_req=1, iord=1; sw asserts wmem=1 only in the completing cycle, then next=IF; lw next=WB on mem_ready.
REQ-026 WB: wreg=1; regrt=1 for I-type; m2reg=1 for lw; next=IF.
REQ-027 Wait counter clears on entry to IF/MEM and increments per non-ready cycle.
REQ-028 Timeout: when the counter reaches WAIT_MAX without ready, mem_err=1 for one cycle, no write enables, next=IF; IF timeout retries the same PC.
REQ-029 mem_ready asserted in the same cycle as the timeout takes priority: the access completes normally.
REQ-030 Every write enable is high for at most one cycle per instruction.

Reset
REQ-031 resetn low: state=IF, counter=0, all outputs 0 (mem_req gated off) regardless of clock.
REQ-032 Reset asserted mid-instruction aborts it with no further writes; first mem_req after the first clock edge following deassertion.

Configuration
REQ-033 HAMMING_EN defined: R-type func 110001 decoded, aluc=1001, path EXE->WB.
REQ-034 HAMMING_EN undefined: func 110001 treated as illegal per REQ-021.

Structure
REQ-035 Shared package holds: state enumeration, aluc encodings, op/func opcode constants.
REQ-036 One sub-module, mc_decode: combinational decode of op/func to instruction one-hots plus a legal flag.

Verification
REQ-037 add (op 0, func 100000), mem_ready always 1 -> IF,ID,EXE,WB; wreg=1 only in WB; aluc=0000; 4 cycles.
REQ-038 lw with mem_ready low 3 cycles in MEM -> MEM held 4 cycles, m2reg=1, regrt=1 in WB; 8 cycles total.
REQ-039 beq with z=1 then z=0 -> wpc=1, pcsource=01 in EXE only for z=1; both return to IF after 3 cycles.
REQ-040 mem_ready never asserted in IF, WAIT_MAX=3 -> mem_err pulse after 3 wait cycles, state IF, wpc/wir stay 0.
REQ-041 func 110001 -> with HAMMING_EN: wreg in WB, aluc=1001; without it: ill_instr pulse in ID, no wreg.
REQ-042 resetn low during MEM of sw with mem_ready=1 -> wmem=0, state=IF immediately.
